// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the core's data-memory port. Takes one load or
//   store at a time over a valid/ready request handshake and waits a fixed
//   number of cycles (WAIT). It then performs the access on an internal word
//   array and returns the result over a valid/ready response handshake.
//   Addresses are word indices.
//
// Parameters
//   ADDR_W : word-address width of the internal array (DEPTH = 2**ADDR_W)
//   WAIT   : wait states between request accept and access (0..15)
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous reset, active low
//   req_valid  : request present
//   req_ready  : responder can accept a request (low while rst is low)
//   req_we     : 1 = store, 0 = load
//   req_addr   : word address
//   req_wdata  : store data
//   req_wstrb  : byte-lane enables for stores
//   rsp_valid  : response present
//   rsp_ready  : requester accepts the response
//   rsp_rdata  : load data (0 for stores and errors)
//   rsp_err    : address out of range
module dmem_responder #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  logic        r_rsp_valid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_access;
  logic              w_complete;
  logic              w_acc_we;
  logic [31:0]       w_acc_addr;
  logic [31:0]       w_acc_wdata;
  logic [3:0]        w_acc_wstrb;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_idx;

  // Next-state logic. With WAIT = 0 the access happens on the accept edge,
  // so IDLE goes straight to RESP.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_access     = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (WAIT == 0) begin
            w_access     = 1'b1;
            w_state_next = S_RESP;
          end else begin
            w_cnt_next   = WAIT_INIT;
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_access     = 1'b1;
          w_state_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_complete   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // An access in IDLE only happens when WAIT = 0, and then it uses the live
  // request fields. Every other access uses the captured fields.
  assign w_acc_we    = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_acc_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_acc_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_acc_wstrb = (r_state == S_IDLE) ? req_wstrb : r_wstrb;
  assign w_in_range  = ((w_acc_addr >> ADDR_W) == 32'd0);
  assign w_idx       = w_acc_addr[ADDR_W-1:0];

  assign req_ready = rst && (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_wstrb <= req_wstrb;
    end
  end

  // Load data is the array word as it was before any write on the same edge.
  // The write below is non-blocking, so this read sees the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
    end else if (w_access) begin
      r_rsp_valid <= 1'b1;
      r_err       <= !w_in_range;
      r_rdata     <= (w_in_range && !w_acc_we) ? r_mem[w_idx] : 32'd0;
    end else if (w_complete) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // The array is never reset. The rst term keeps a reset edge from
  // committing a store.
  always_ff @(posedge clk) begin
    if (rst && w_access && w_acc_we && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_wstrb[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Self-checking bench for dmem_responder. The main instance (ADDR_W=8,
//   WAIT=2) is compared every cycle against a transaction-level model: a
//   word array with per-byte "known" flags and a latency counter per
//   request. A second instance with WAIT=0 covers the zero-wait build.
module tb_dmem_responder;

  localparam int TA = 8;
  localparam int TW = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        z_req_valid;
  logic        z_req_ready;
  logic        z_req_we;
  logic [31:0] z_req_addr;
  logic [31:0] z_req_wdata;
  logic [3:0]  z_req_wstrb;
  logic        z_rsp_valid;
  logic        z_rsp_ready;
  logic [31:0] z_rsp_rdata;
  logic        z_rsp_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  dmem_responder #(.ADDR_W(TA), .WAIT(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.ADDR_W(TA), .WAIT(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_wstrb(z_req_wstrb),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural model. A request becomes outstanding when accepted. Its
  // access happens TW edges after the accept edge (an age count). It then
  // stays visible until it is handed off.
  logic [31:0] mmem [256];
  bit   [3:0]  mkn  [256];
  bit          m_busy  = 1'b0;
  bit          m_valid = 1'b0;
  int          m_age   = 0;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic [31:0] m_mask;
  bit          m_err;

  function automatic void doAccess();
    int idx;
    idx     = int'(m_addr[7:0]);
    m_valid = 1'b1;
    m_mask  = 32'hFFFF_FFFF;
    if ((m_addr >> 8) != 32'd0) begin
      m_err   = 1'b1;
      m_rdata = 32'd0;
    end else if (m_we) begin
      m_err   = 1'b0;
      m_rdata = 32'd0;
      for (int i = 0; i < 4; i++) begin
        if (m_wstrb[i]) begin
          mmem[idx][8*i +: 8] = m_wdata[8*i +: 8];
          mkn[idx][i] = 1'b1;
        end
      end
    end else begin
      m_err   = 1'b0;
      m_rdata = mmem[idx];
      for (int i = 0; i < 4; i++) m_mask[8*i +: 8] = {8{mkn[idx][i]}};
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      if (m_valid) begin
        if (rsp_ready) begin
          m_valid = 1'b0;
          m_busy  = 1'b0;
        end
      end else if (m_busy) begin
        m_age++;
        if (m_age == TW) doAccess();
      end else if (req_valid) begin
        m_busy  = 1'b1;
        m_age   = 0;
        m_we    = req_we;
        m_addr  = req_addr;
        m_wdata = req_wdata;
        m_wstrb = req_wstrb;
        if (TW == 0) doAccess();
      end
    end
  end

  always @(negedge rst) begin
    m_busy  = 1'b0;
    m_valid = 1'b0;
  end

  // Compare process: every falling edge, main instance against the model.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("reset req_ready", 32'(req_ready), 32'd0);
      checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
      checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
    end else begin
      checkOutput("req_ready", 32'(req_ready), 32'(!m_busy));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
        checkOutput("rsp_rdata", rsp_rdata & m_mask, m_rdata & m_mask);
        checkOutput("rsp_err", 32'(rsp_err), 32'(m_err));
      end
    end
  end

  // One full transaction on the main instance, holding rsp_ready low for bp
  // cycles after the response appears.
  task automatic applyStimulus(input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input int bp, output logic [31:0] rdata,
                               output logic err);
    int n;
    int accEdge;
    rdata = 32'hX;
    err   = 1'bX;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checkOutput("accept timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    accEdge = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      checkOutput("response timeout", 32'(rsp_valid), 32'd1);
      return;
    end
    checkOutput("response latency", 32'(cyc - accEdge), 32'(TW));
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int k = 0; k < bp; k++) begin
      checkOutput("held rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("held rsp_rdata", rsp_rdata, rdata);
      checkOutput("held req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("ready after handoff", 32'(req_ready), 32'd1);
    checkOutput("valid after handoff", 32'(rsp_valid), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] zval [3];
  logic [31:0] addrR;
  int          zStart;

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_wstrb = 4'd0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'd0;
    z_req_wdata = 32'd0; z_req_wstrb = 4'd0; z_rsp_ready = 1'b0;
    zval[0] = 32'h0BAD_F00D; zval[1] = 32'h1357_9BDF; zval[2] = 32'hFEDC_BA98;

    repeat (3) @(negedge clk);
    #3 rst = 1'b1;

    $display("[TB] store/load round trip");
    applyStimulus(1'b1, 32'h05, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
    checkOutput("store rdata", rd, 32'd0);
    applyStimulus(1'b0, 32'h05, 32'h0, 4'h0, 0, rd, er);
    checkOutput("load 0x05", rd, 32'hDEAD_BEEF);
    checkOutput("load 0x05 err", 32'(er), 32'd0);

    $display("[TB] byte strobes");
    applyStimulus(1'b1, 32'h09, 32'h1122_3344, 4'hF, 0, rd, er);
    applyStimulus(1'b1, 32'h09, 32'hAABB_CCDD, 4'h5, 1, rd, er);
    applyStimulus(1'b0, 32'h09, 32'h0, 4'hA, 0, rd, er);
    checkOutput("strobed load", rd, 32'h11BB_33DD);
    applyStimulus(1'b1, 32'h09, 32'hFFFF_FFFF, 4'h0, 0, rd, er);
    checkOutput("zero strobe err", 32'(er), 32'd0);
    applyStimulus(1'b0, 32'h09, 32'h0, 4'h0, 0, rd, er);
    checkOutput("zero strobe unchanged", rd, 32'h11BB_33DD);

    $display("[TB] out of range");
    applyStimulus(1'b1, 32'h00, 32'h0123_4567, 4'hF, 0, rd, er);
    applyStimulus(1'b0, 32'h100, 32'h0, 4'h0, 0, rd, er);
    checkOutput("oor load err", 32'(er), 32'd1);
    checkOutput("oor load rdata", rd, 32'd0);
    applyStimulus(1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
    checkOutput("oor store err", 32'(er), 32'd1);
    checkOutput("oor store rdata", rd, 32'd0);
    applyStimulus(1'b0, 32'h00, 32'h0, 4'h0, 0, rd, er);
    checkOutput("no corruption 0x00", rd, 32'h0123_4567);

    $display("[TB] backpressure");
    applyStimulus(1'b0, 32'h05, 32'h0, 4'h0, 5, rd, er);
    checkOutput("backpressure load", rd, 32'hDEAD_BEEF);

    $display("[TB] reset during wait");
    applyStimulus(1'b1, 32'h07, 32'h0, 4'hF, 0, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h07;
    req_wdata = 32'hCAFE_F00D; req_wstrb = 4'hF;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("mid-wait reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid-wait reset req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    applyStimulus(1'b0, 32'h07, 32'h0, 4'h0, 0, rd, er);
    checkOutput("abandoned store", rd, 32'h0);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 150; t++) begin
      addrR = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) addrR = addrR | (32'($urandom_range(1, 32'hFFFFFF)) << 8);
      applyStimulus(1'($urandom), addrR, $urandom, 4'($urandom),
                    int'($urandom_range(0, 3)), rd, er);
    end

    $display("[TB] zero-wait instance");
    @(negedge clk);
    z_rsp_ready = 1'b1;
    zStart = cyc;
    for (int i = 0; i < 6; i++) begin
      checkOutput("z req_ready idle", 32'(z_req_ready), 32'd1);
      z_req_valid = 1'b1;
      z_req_we    = (i < 3);
      z_req_addr  = 32'(20 + (i % 3));
      z_req_wdata = zval[i % 3];
      z_req_wstrb = 4'hF;
      @(negedge clk);
      checkOutput("z rsp_valid next cycle", 32'(z_rsp_valid), 32'd1);
      checkOutput("z req_ready busy", 32'(z_req_ready), 32'd0);
      checkOutput("z rsp_rdata", z_rsp_rdata, (i < 3) ? 32'd0 : zval[i % 3]);
      checkOutput("z rsp_err", 32'(z_rsp_err), 32'd0);
      @(negedge clk);
    end
    checkOutput("z back-to-back edges", 32'(cyc - zStart), 32'd12);
    z_req_valid = 1'b0;
    z_rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
